// File: rtl/t_ff_counter_ctrl_pkg.sv
// Shared definitions for the T flip-flop counter controller.
// Holds the FSM state encodings and the default bank width.
package t_ff_counter_ctrl_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

endpackage

// File: rtl/t_ff_counter_ctrl_cell.sv
// Single toggle flip-flop cell with synchronous active-high reset.
// Q flips on every rising edge where T is high.
module t_ff_cell (
    input  logic CLK,
    input  logic RST,
    input  logic T,
    output logic Q,
    output logic Qbar
);

    always_ff @(posedge CLK) begin
        if (RST) Q <= 1'b0;
        else     Q <= Q ^ T;
    end

    assign Qbar = ~Q;

endmodule

// File: rtl/t_ff_counter_ctrl.sv
// Programmable-modulus up/down counter whose only count storage is a bank of
// toggle cells; each edge drives T = Q ^ Qnext with load, wrap and one-shot stop.
module t_ff_counter_ctrl
    import t_ff_counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             ONESHOT,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] MAX,
    output logic [WIDTH-1:0] COUNT,
    output logic             TC,
    output logic             WRAP,
    output logic             DONE
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qbar;
    logic [WIDTH-1:0] w_qnext;
    logic [WIDTH-1:0] w_t;
    logic             w_zero;
    logic             w_tc;
    logic             w_cnt_edge;
    logic             w_stop_edge;
    logic             w_wrap_nxt;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_wrap;
    logic             r_done;

    // All-ones Qbar is the cheapest zero detect off the bank.
    assign w_zero      = &w_qbar;
    assign w_tc        = UP ? (w_q == MAX) : w_zero;
    assign w_cnt_edge  = EN && !LOAD && (r_state != ST_STOP);
    assign w_stop_edge = w_cnt_edge && ONESHOT && w_tc;

    always_comb begin
        w_qnext    = w_q;
        w_wrap_nxt = 1'b0;
        if (LOAD) begin
            w_qnext = (D > MAX) ? MAX : D;
        end else if (w_cnt_edge && !w_stop_edge) begin
            if (UP) begin
                // >= so a count stranded above a lowered MAX wraps home.
                if (w_q >= MAX) begin
                    w_qnext    = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_qnext = w_q + WIDTH'(1);
                end
            end else if (w_zero) begin
                w_qnext    = MAX;
                w_wrap_nxt = 1'b1;
            end else begin
                w_qnext = w_q - WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (LOAD)                  w_state_nxt = EN ? ST_RUN : ST_IDLE;
        else if (!EN)              w_state_nxt = ST_IDLE;
        else if (w_stop_edge)      w_state_nxt = ST_STOP;
        else if (r_state == ST_IDLE) w_state_nxt = ST_RUN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wrap  <= w_wrap_nxt;
            r_done  <= (w_state_nxt == ST_STOP);
        end
    end

    assign w_t = w_q ^ w_qnext;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        t_ff_cell u_cell (
            .CLK  (CLK),
            .RST  (RST),
            .T    (w_t[gi]),
            .Q    (w_q[gi]),
            .Qbar (w_qbar[gi])
        );
    end

    assign COUNT = w_q;
    assign TC    = w_tc;
    assign WRAP  = r_wrap;
    assign DONE  = r_done;

endmodule

// File: tb/tb_t_ff_counter_ctrl.sv
// Bench for t_ff_counter_ctrl: directed scenarios plus a randomized run
// against an arithmetic reference model of the counter.
module tb_t_ff_counter_ctrl;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST, EN, UP, ONESHOT, LOAD;
    logic [W-1:0] D, MAX;
    logic [W-1:0] COUNT;
    logic         TC, WRAP, DONE;

    int errors = 0;
    int checks = 0;

    int unsigned m_count = 0;
    bit          m_stop  = 0;
    bit          m_wrap  = 0;

    t_ff_counter_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .ONESHOT(ONESHOT),
        .LOAD(LOAD), .D(D), .MAX(MAX), .COUNT(COUNT), .TC(TC),
        .WRAP(WRAP), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Advance the model by the rules for the current inputs, then clock the DUT.
    task automatic clk_edge();
        int unsigned mx;
        int unsigned c;
        bit          tc;
        mx = MAX;
        c  = m_count;
        tc = UP ? (c == mx) : (c == 0);
        if (RST) begin
            m_count = 0; m_stop = 0; m_wrap = 0;
        end else if (LOAD) begin
            m_count = (D > MAX) ? mx : D;
            m_stop  = 0; m_wrap = 0;
        end else if (EN && !m_stop) begin
            m_wrap = 0;
            if (ONESHOT && tc) m_stop = 1;
            else if (UP) begin
                if (c >= mx) begin m_count = 0; m_wrap = 1; end
                else m_count = c + 1;
            end else begin
                if (c == 0) begin m_count = mx; m_wrap = 1; end
                else m_count = c - 1;
            end
        end else begin
            m_wrap = 0;
            if (!EN) m_stop = 0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1; EN = 1; UP = 1; ONESHOT = 0; LOAD = 0; D = '0; MAX = 4'd9;
        clk_edge();
        clk_edge();
        checks++; if (COUNT !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
        checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", WRAP); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", DONE); end
        RST = 0; EN = 0; UP = 0; #1;
        checks++; if (TC !== 1'b1) begin errors++; $display("FAIL reset_tc_down got=%b exp=1", TC); end
        UP = 1; MAX = 4'd9; #1;
        checks++; if (TC !== 1'b0) begin errors++; $display("FAIL reset_tc_up got=%b exp=0", TC); end
    endtask

    task automatic test_mod10_up();
        int wraps = 0;
        MAX = 4'd9; UP = 1; EN = 1; LOAD = 0; ONESHOT = 0;
        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] exp_c;
            exp_c = W'((i + 1) % 10);
            clk_edge();
            if (WRAP === 1'b1) wraps++;
            checks++; if (COUNT !== exp_c) begin errors++; $display("FAIL mod10_count step=%0d got=%0d exp=%0d", i, COUNT, exp_c); end
            checks++; if (WRAP !== (exp_c == 0)) begin errors++; $display("FAIL mod10_wrap step=%0d got=%b exp=%b", i, WRAP, exp_c == 0); end
        end
        checks++; if (wraps != 1) begin errors++; $display("FAIL mod10_wrap_total got=%0d exp=1", wraps); end
    endtask

    task automatic test_down_load_clamp();
        LOAD = 1; D = 4'd12; MAX = 4'd9; EN = 0;
        clk_edge();
        checks++; if (COUNT !== 4'd9) begin errors++; $display("FAIL clamp_load got=%0d exp=9", COUNT); end
        LOAD = 0; UP = 0; EN = 1;
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] exp_c;
            exp_c = (i < 9) ? W'(8 - i) : 4'd9;
            clk_edge();
            checks++; if (COUNT !== exp_c) begin errors++; $display("FAIL down_count step=%0d got=%0d exp=%0d", i, COUNT, exp_c); end
            checks++; if (WRAP !== (i == 9)) begin errors++; $display("FAIL down_wrap step=%0d got=%b exp=%b", i, WRAP, i == 9); end
        end
    endtask

    task automatic test_oneshot();
        logic [W-1:0] exp_c [5] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
        logic         exp_d [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        LOAD = 1; D = 4'd0; MAX = 4'd3; EN = 0; ONESHOT = 0;
        clk_edge();
        LOAD = 0; ONESHOT = 1; UP = 1; EN = 1;
        for (int i = 0; i < 5; i++) begin
            clk_edge();
            checks++; if (COUNT !== exp_c[i]) begin errors++; $display("FAIL oneshot_count step=%0d got=%0d exp=%0d", i, COUNT, exp_c[i]); end
            checks++; if (DONE !== exp_d[i]) begin errors++; $display("FAIL oneshot_done step=%0d got=%b exp=%b", i, DONE, exp_d[i]); end
            checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL oneshot_wrap step=%0d got=%b exp=0", i, WRAP); end
        end
        EN = 0;
        clk_edge();
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL oneshot_release_done got=%b exp=0", DONE); end
        checks++; if (COUNT !== 4'd3) begin errors++; $display("FAIL oneshot_release_count got=%0d exp=3", COUNT); end
        ONESHOT = 0; EN = 1;
        clk_edge();
        checks++; if (COUNT !== 4'd0 || WRAP !== 1'b1) begin errors++; $display("FAIL oneshot_idle_resume got=%0d/%b exp=0/1", COUNT, WRAP); end
    endtask

    task automatic test_simultaneous();
        LOAD = 1; D = 4'd5; MAX = 4'd9; EN = 0;
        clk_edge();
        LOAD = 1; D = 4'd2; EN = 1; UP = 1;
        clk_edge();
        checks++; if (COUNT !== 4'd2) begin errors++; $display("FAIL load_over_count got=%0d exp=2", COUNT); end
        RST = 1; LOAD = 1; D = 4'd7;
        clk_edge();
        checks++; if (COUNT !== 4'd0) begin errors++; $display("FAIL rst_over_load got=%0d exp=0", COUNT); end
        RST = 0; LOAD = 0;
    endtask

    task automatic test_max_lowered();
        LOAD = 1; D = 4'd7; MAX = 4'd9; EN = 0;
        clk_edge();
        LOAD = 0; MAX = 4'd4; UP = 1; EN = 1; ONESHOT = 0;
        clk_edge();
        checks++; if (COUNT !== 4'd0 || WRAP !== 1'b1) begin errors++; $display("FAIL max_lowered_up got=%0d/%b exp=0/1", COUNT, WRAP); end
        LOAD = 1; D = 4'd7; MAX = 4'd9; EN = 0;
        clk_edge();
        LOAD = 0; MAX = 4'd4; UP = 0; EN = 1;
        clk_edge();
        checks++; if (COUNT !== 4'd6 || WRAP !== 1'b0) begin errors++; $display("FAIL max_lowered_down got=%0d/%b exp=6/0", COUNT, WRAP); end
    endtask

    task automatic test_max_zero();
        LOAD = 1; D = 4'd5; MAX = 4'd0; EN = 0; ONESHOT = 0;
        clk_edge();
        checks++; if (COUNT !== 4'd0) begin errors++; $display("FAIL max0_load got=%0d exp=0", COUNT); end
        LOAD = 0; EN = 1; UP = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) UP = 0;
            clk_edge();
            checks++; if (COUNT !== 4'd0 || WRAP !== 1'b1) begin errors++; $display("FAIL max0_freerun step=%0d got=%0d/%b exp=0/1", i, COUNT, WRAP); end
        end
        ONESHOT = 1;
        clk_edge();
        checks++; if (DONE !== 1'b1 || WRAP !== 1'b0) begin errors++; $display("FAIL max0_oneshot got done=%b wrap=%b exp 1/0", DONE, WRAP); end
        ONESHOT = 0; EN = 0;
        clk_edge();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            RST  = ($urandom_range(0, 49) == 0);
            LOAD = ($urandom_range(0, 7) == 0);
            EN   = ($urandom_range(0, 3) != 0);
            UP   = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) ONESHOT = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0)  MAX = W'($urandom_range(0, 15));
            D = W'($urandom_range(0, 15));
            clk_edge();
            checks++; if (COUNT !== W'(m_count)) begin errors++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, COUNT, m_count); end
            checks++; if (WRAP !== m_wrap) begin errors++; $display("FAIL rnd_wrap i=%0d got=%b exp=%b", i, WRAP, m_wrap); end
            checks++; if (DONE !== m_stop) begin errors++; $display("FAIL rnd_done i=%0d got=%b exp=%b", i, DONE, m_stop); end
            checks++; if (TC !== (UP ? (m_count == MAX) : (m_count == 0))) begin
                errors++; $display("FAIL rnd_tc i=%0d got=%b count=%0d max=%0d up=%b", i, TC, m_count, MAX, UP);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mod10_up();
        test_down_load_clamp();
        test_oneshot();
        test_simultaneous();
        test_max_lowered();
        test_max_zero();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
